// File: rtl/ir_fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// ir_fetch_sequencer_if
//   Bundles the two buses driven by the instruction fetch sequencer:
//   - byte-wide memory read port (req/ack handshake)
//   - FunSel/E/I load port of the 16-bit instruction register
//
//   mem_addr   16  byte address to memory          (master -> slave)
//   mem_req     1  memory read request             (master -> slave)
//   mem_ack     1  memory data valid               (slave  -> master)
//   mem_data    8  read byte, valid with mem_ack   (slave  -> master)
//   ir_funsel   3  FunSel to the IR register       (master -> slave)
//   ir_e        1  enable to the IR register       (master -> slave)
//   ir_i       16  data to the IR register         (master -> slave)
// ----------------------------------------------------------------------------
interface ir_fetch_sequencer_if;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [2:0]  ir_funsel;
    logic        ir_e;
    logic [15:0] ir_i;

    modport master (
        output mem_addr, mem_req, ir_funsel, ir_e, ir_i,
        input  mem_ack, mem_data
    );

    modport slave (
        input  mem_addr, mem_req, ir_funsel, ir_e, ir_i,
        output mem_ack, mem_data
    );
endinterface

// File: rtl/ir_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// ir_fetch_sequencer
//   Fetches one 16-bit instruction as two byte reads from a byte-wide memory
//   and writes each byte into the instruction register using partial-load
//   FunSel codes (101 = load low byte, 110 = load high byte). Owns the fetch
//   program counter. All outputs are registered (Moore).
//
//   Optional feature: define FETCH_TIMEOUT_EN to abort a fetch when memory
//   does not acknowledge within TIMEOUT cycles (Error pulse). Without it the
//   sequencer waits for mem_ack indefinitely and error_o is tied low.
//
// Parameters
//   LOW_FIRST  1: byte at PC -> IR[7:0], byte at PC+1 -> IR[15:8]; 0: reversed
//   PC_RESET   PC value after reset
//   TIMEOUT    REQ cycles without mem_ack before abort (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start_i    request one fetch (sampled in IDLE only)
//   pc_load_i  load PC from pc_in_i (IDLE only, wins over start_i)
//   pc_in_i    new PC value
//   pc_out_o   current fetch PC
//   busy_o     high in every state except IDLE
//   done_o     one-cycle pulse, fetch complete
//   error_o    one-cycle pulse, fetch aborted on timeout
//   bus        memory + IR port bundle (master side)
// ----------------------------------------------------------------------------
module ir_fetch_sequencer #(
    parameter bit          LOW_FIRST = 1'b1,
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        pc_load_i,
    input  logic [15:0]                 pc_in_i,
    output logic [15:0]                 pc_out_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    ir_fetch_sequencer_if.master        bus
);

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
        $error("ir_fetch_sequencer: TIMEOUT must be in 1..15");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ_1  = 3'd1;
    localparam logic [2:0] S_LOAD_1 = 3'd2;
    localparam logic [2:0] S_REQ_2  = 3'd3;
    localparam logic [2:0] S_LOAD_2 = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
`endif

    localparam logic [2:0] FS_LOW    = 3'b101;
    localparam logic [2:0] FS_HIGH   = 3'b110;
    localparam logic [2:0] FS_FIRST  = LOW_FIRST ? FS_LOW  : FS_HIGH;
    localparam logic [2:0] FS_SECOND = LOW_FIRST ? FS_HIGH : FS_LOW;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_req_q, mem_req_d;
    logic        ir_e_q, ir_e_d;
    logic [2:0]  ir_funsel_q, ir_funsel_d;
    logic [15:0] ir_i_q, ir_i_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        is_req_q, is_req_d, is_load_d;

    assign is_req_q  = (state_q == S_REQ_1) || (state_q == S_REQ_2);
    assign is_req_d  = (state_d == S_REQ_1) || (state_d == S_REQ_2);
    assign is_load_d = (state_d == S_LOAD_1) || (state_d == S_LOAD_2);

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt_q, tmo_cnt_d;
    logic       error_q, error_d;

    // Counts consecutive unacknowledged REQ cycles; any state change clears it.
    assign tmo_cnt_d = (is_req_q && state_d == state_q) ? tmo_cnt_q + 4'd1 : 4'd0;
    assign error_d   = (state_d == S_ERR);
    assign error_o   = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 4'd0;
            error_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            error_q   <= error_d;
        end
    end
`else
    assign error_o = 1'b0;
`endif

    // Next state and PC.
    always_comb begin
        // NOTE: defaults first so every path assigns every target -- no latches.
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (pc_load_i) begin
                    pc_d = pc_in_i;
                end else if (start_i) begin
                    state_d = S_REQ_1;
                end
            end
            S_REQ_1, S_REQ_2: begin
                if (bus.mem_ack) begin
                    pc_d    = pc_q + 16'd1;
                    state_d = (state_q == S_REQ_1) ? S_LOAD_1 : S_LOAD_2;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_LOAD_1: state_d = S_REQ_2;
            S_LOAD_2: state_d = S_DONE;
            default:  state_d = S_IDLE;  // DONE, ERR and unused codes
        endcase
    end

    // Outputs are computed from the state being entered so they are valid
    // for the whole cycle of that state. The IR data register also serves as
    // the byte latch: it captures mem_data on the acknowledging edge.
    always_comb begin
        mem_req_d   = is_req_d;
        mem_addr_d  = is_req_d ? pc_d : mem_addr_q;
        ir_e_d      = is_load_d;
        ir_i_d      = is_load_d ? {8'h00, bus.mem_data} : ir_i_q;
        ir_funsel_d = ir_funsel_q;
        if (state_d == S_LOAD_1) begin
            ir_funsel_d = FS_FIRST;
        end else if (state_d == S_LOAD_2) begin
            ir_funsel_d = FS_SECOND;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            mem_addr_q  <= 16'h0000;
            mem_req_q   <= 1'b0;
            ir_e_q      <= 1'b0;
            ir_funsel_q <= 3'b000;
            ir_i_q      <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            ir_e_q      <= ir_e_d;
            ir_funsel_q <= ir_funsel_d;
            ir_i_q      <= ir_i_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pc_out_o      = pc_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.ir_e      = ir_e_q;
    assign bus.ir_funsel = ir_funsel_q;
    assign bus.ir_i      = ir_i_q;

endmodule
